// File: rtl/bias_buffer_mlane_if.sv
// -----------------------------------------------------------------------------
// bias_buffer_mlane_if
// Bundles the burst-load stream and the multi-lane read handshake of the bias
// buffer.
//   master : the DMA/bias-load agent and the bias-adder requester
//   slave  : the bias buffer itself
// Load side : ld_start, ld_base, ld_len, ld_valid, ld_data -> ld_ready, ld_done
// Read side : rd_req, rd_addr -> rd_ready, rd_valid, rd_data (LANES words)
// -----------------------------------------------------------------------------
interface bias_buffer_mlane_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_BIT = 7,
   parameter int LANES    = 8
);
   logic                      ld_start;
   logic [ADDR_BIT-1:0]       ld_base;
   logic [ADDR_BIT:0]         ld_len;
   logic                      ld_valid;
   logic [DATA_W-1:0]         ld_data;
   logic                      ld_ready;
   logic                      ld_done;
   logic                      rd_req;
   logic [ADDR_BIT-1:0]       rd_addr;
   logic                      rd_ready;
   logic                      rd_valid;
   logic [LANES*DATA_W-1:0]   rd_data;

   modport master (
      output ld_start, ld_base, ld_len, ld_valid, ld_data, rd_req, rd_addr,
      input  ld_ready, ld_done, rd_ready, rd_valid, rd_data
   );

   modport slave (
      input  ld_start, ld_base, ld_len, ld_valid, ld_data, rd_req, rd_addr,
      output ld_ready, ld_done, rd_ready, rd_valid, rd_data
   );
endinterface

// File: rtl/bias_buffer_mlane.sv
// -----------------------------------------------------------------------------
// bias_buffer_mlane
// Per-output-channel bias store for the int8 datapath. Biases arrive as a
// valid/ready burst stream; a read returns LANES consecutive words, one per PE
// column, one cycle after acceptance.
// Ports:
//   CLK  : single clock, rising edge
//   RST  : synchronous, active-high reset
//   bus  : bias_buffer_mlane_if.slave (load stream + read handshake)
// Parameters:
//   DATA_W, ADDR_BIT (DEPTH = 2**ADDR_BIT), LANES (1..DEPTH),
//   WRAP (1: lanes wrap modulo DEPTH, 0: lanes past the top read as zero)
// -----------------------------------------------------------------------------
module bias_buffer_mlane #(
   parameter int DATA_W   = 32,
   parameter int ADDR_BIT = 7,
   parameter int LANES    = 8,
   parameter bit WRAP     = 1'b1
) (
   input  logic                CLK,
   input  logic                RST,
   bias_buffer_mlane_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_BIT;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t                    state_q, state_d;
   logic [ADDR_BIT-1:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_BIT:0]         remaining_q, remaining_d;
   logic                      ld_done_q, ld_done_d;
   logic                      wr_en;
   logic                      rd_accept;
   logic                      rd_valid_q;
   logic [LANES*DATA_W-1:0]   rd_data_q;
   logic [LANES*DATA_W-1:0]   rd_lanes_d;

   logic [DATA_W-1:0]         ram_q [DEPTH];

   // ---------------------------------------------------------------------------
   // Load FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         remaining_q <= '0;
         ld_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         remaining_q <= remaining_d;
         ld_done_q   <= ld_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      remaining_d = remaining_q;
      ld_done_d   = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ld_start) begin
               if (bus.ld_len != '0) begin
                  state_d     = LOAD;
                  wr_ptr_d    = bus.ld_base;
                  remaining_d = bus.ld_len;
               end else begin
                  // Empty burst completes immediately without touching memory.
                  ld_done_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (bus.ld_valid) begin
               wr_en       = 1'b1;
               // Write pointer always wraps, regardless of the read policy.
               wr_ptr_d    = wr_ptr_q + ADDR_BIT'(1);
               remaining_d = remaining_q - (ADDR_BIT+1)'(1);
               if (remaining_q == (ADDR_BIT+1)'(1)) begin
                  state_d   = IDLE;
                  ld_done_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ld_ready = (state_q == LOAD);
   assign bus.ld_done  = ld_done_q;
   assign bus.rd_ready = (state_q == IDLE);

   // ---------------------------------------------------------------------------
   // Bias storage (contents survive reset; a beat on a reset edge is dropped)
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (wr_en && !RST) begin
         ram_q[wr_ptr_q] <= bus.ld_data;
      end
   end

   // ---------------------------------------------------------------------------
   // Lane address generation; the extra address bit flags a run past the top.
   // ---------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic [ADDR_BIT:0] lane_addr;
         assign lane_addr = {1'b0, bus.rd_addr} + (ADDR_BIT+1)'(gi);
         if (WRAP) begin : g_wrap
            assign rd_lanes_d[gi*DATA_W +: DATA_W] = ram_q[lane_addr[ADDR_BIT-1:0]];
         end else begin : g_zero
            assign rd_lanes_d[gi*DATA_W +: DATA_W] =
               lane_addr[ADDR_BIT] ? '0 : ram_q[lane_addr[ADDR_BIT-1:0]];
         end
      end
   endgenerate

   // Reads are only accepted in IDLE, so they never race a burst write.
   assign rd_accept = bus.rd_req && (state_q == IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) begin
            rd_data_q <= rd_lanes_d;
         end
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_bias_buffer_mlane.sv
// -----------------------------------------------------------------------------
// tb_bias_buffer_mlane
// Drives one stimulus stream into a WRAP=1 and a WRAP=0 instance and compares
// both against an array model of the bias memory.
// -----------------------------------------------------------------------------
module tb_bias_buffer_mlane;
   localparam int DATA_W   = 32;
   localparam int ADDR_BIT = 7;
   localparam int LANES    = 8;
   localparam int DEPTH    = 2 ** ADDR_BIT;
   localparam int LW       = LANES * DATA_W;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   logic                ld_start, ld_valid, rd_req;
   logic [ADDR_BIT-1:0] ld_base, rd_addr;
   logic [ADDR_BIT:0]   ld_len;
   logic [DATA_W-1:0]   ld_data;

   bias_buffer_mlane_if #(.DATA_W(DATA_W), .ADDR_BIT(ADDR_BIT), .LANES(LANES)) if1 ();
   bias_buffer_mlane_if #(.DATA_W(DATA_W), .ADDR_BIT(ADDR_BIT), .LANES(LANES)) if0 ();

   assign if1.ld_start = ld_start;  assign if0.ld_start = ld_start;
   assign if1.ld_base  = ld_base;   assign if0.ld_base  = ld_base;
   assign if1.ld_len   = ld_len;    assign if0.ld_len   = ld_len;
   assign if1.ld_valid = ld_valid;  assign if0.ld_valid = ld_valid;
   assign if1.ld_data  = ld_data;   assign if0.ld_data  = ld_data;
   assign if1.rd_req   = rd_req;    assign if0.rd_req   = rd_req;
   assign if1.rd_addr  = rd_addr;   assign if0.rd_addr  = rd_addr;

   bias_buffer_mlane #(.DATA_W(DATA_W), .ADDR_BIT(ADDR_BIT), .LANES(LANES), .WRAP(1'b1))
      u_dut_wrap (.CLK(CLK), .RST(RST), .bus(if1.slave));
   bias_buffer_mlane #(.DATA_W(DATA_W), .ADDR_BIT(ADDR_BIT), .LANES(LANES), .WRAP(1'b0))
      u_dut_zero (.CLK(CLK), .RST(RST), .bus(if0.slave));

   // Reference model
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] wq [$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] exp_rd(input int addr, input bit wrap);
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) begin
         int a;
         a = addr + i;
         if (wrap)           r[i*DATA_W +: DATA_W] = mem[a % DEPTH];
         else if (a < DEPTH) r[i*DATA_W +: DATA_W] = mem[a];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_read(input string tag, input int addr);
      check({tag, "_valid1"}, LW'(if1.rd_valid), LW'(1));
      check({tag, "_valid0"}, LW'(if0.rd_valid), LW'(1));
      check({tag, "_data_wrap"}, if1.rd_data, exp_rd(addr, 1'b1));
      check({tag, "_data_zero"}, if0.rd_data, exp_rd(addr, 1'b0));
   endtask

   task automatic do_read(input string tag, input int addr);
      rd_req  = 1'b1;
      rd_addr = ADDR_BIT'(addr);
      tick();
      rd_req = 1'b0;
      check_read(tag, addr);
      $display("read  addr=%0d wrap=%h", addr, if1.rd_data);
      tick();
      check({tag, "_nopulse"}, LW'(if1.rd_valid), LW'(0));
      check({tag, "_hold_wrap"}, if1.rd_data, exp_rd(addr, 1'b1));
      check({tag, "_hold_zero"}, if0.rd_data, exp_rd(addr, 1'b0));
   endtask

   // vmode: 0 = valid held high, 1 = toggling, 2 = random (plus stray ld_start).
   // hold_rd: hold rd_req through the burst; sim_rd: issue a read with ld_start.
   // rst_after: assert reset once that many beats have been written (-1 = never).
   task automatic do_load(input string tag, input int base, input int len, input int vmode,
                          input bit hold_rd, input bit sim_rd, input int rd_a, input int rst_after);
      logic [LW-1:0] snap1, snap0;
      int k, cyc;
      bit v;
      snap1 = exp_rd(rd_a, 1'b1);
      snap0 = exp_rd(rd_a, 1'b0);
      ld_start = 1'b1;
      ld_base  = ADDR_BIT'(base);
      ld_len   = (ADDR_BIT+1)'(len);
      ld_valid = (len == 0);
      ld_data  = 32'hDEAD_BEEF;
      if (sim_rd) begin
         rd_req  = 1'b1;
         rd_addr = ADDR_BIT'(rd_a);
      end
      tick();
      ld_start = 1'b0;
      rd_req   = 1'b0;
      ld_valid = 1'b0;
      $display("load  %s base=%0d len=%0d vmode=%0d", tag, base, len, vmode);
      if (sim_rd) begin
         check({tag, "_simrd_valid"}, LW'(if1.rd_valid), LW'(1));
         check({tag, "_simrd_wrap"}, if1.rd_data, snap1);
         check({tag, "_simrd_zero"}, if0.rd_data, snap0);
      end
      if (len == 0) begin
         check({tag, "_zl_done"}, LW'(if1.ld_done), LW'(1));
         check({tag, "_zl_ready"}, LW'(if1.ld_ready), LW'(0));
         check({tag, "_zl_rdready"}, LW'(if1.rd_ready), LW'(1));
         tick();
         check({tag, "_zl_done_off"}, LW'(if1.ld_done), LW'(0));
         return;
      end
      check({tag, "_ready_start"}, LW'(if1.ld_ready), LW'(1));
      if (hold_rd) begin
         rd_req  = 1'b1;
         rd_addr = ADDR_BIT'(rd_a);
      end
      k = 0;
      cyc = 0;
      while (k < len) begin
         if (rst_after >= 0 && k == rst_after) begin
            RST = 1'b1;
            tick();
            RST = 1'b0;
            check({tag, "_rst_ready"}, LW'(if1.ld_ready), LW'(0));
            check({tag, "_rst_done"}, LW'(if1.ld_done), LW'(0));
            check({tag, "_rst_rdvalid"}, LW'(if1.rd_valid), LW'(0));
            check({tag, "_rst_data1"}, if1.rd_data, LW'(0));
            check({tag, "_rst_data0"}, if0.rd_data, LW'(0));
            check({tag, "_rst_idle"}, LW'(if1.rd_ready), LW'(1));
            return;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         ld_valid = v;
         ld_data  = wq[k];
         ld_start = (vmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         ld_len   = (ADDR_BIT+1)'($urandom_range(0, DEPTH));
         tick();
         if (v) begin
            mem[(base + k) % DEPTH] = wq[k];
            k++;
         end
         cyc++;
         if (k < len) begin
            check({tag, "_ready_mid"}, LW'(if1.ld_ready), LW'(1));
            check({tag, "_done_mid"}, LW'(if1.ld_done), LW'(0));
            if (hold_rd) begin
               check({tag, "_blocked"}, LW'(if1.rd_ready), LW'(0));
               check({tag, "_noread"}, LW'(if1.rd_valid), LW'(0));
            end
         end
      end
      ld_valid = 1'b0;
      ld_start = 1'b0;
      check({tag, "_done"}, LW'(if1.ld_done), LW'(1));
      check({tag, "_ready_end"}, LW'(if1.ld_ready), LW'(0));
      check({tag, "_rdready_end"}, LW'(if1.rd_ready), LW'(1));
      if (hold_rd) begin
         tick();
         rd_req = 1'b0;
         check_read({tag, "_heldrd"}, rd_a);
      end else begin
         tick();
      end
      check({tag, "_done_off"}, LW'(if1.ld_done), LW'(0));
   endtask

   task automatic fill(input int n, input int first, input bit rnd);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back(rnd ? $urandom : DATA_W'(first + i));
   endtask

   initial begin
      RST = 1'b1; ld_start = 0; ld_valid = 0; rd_req = 0;
      ld_base = '0; ld_len = '0; ld_data = '0; rd_addr = '0;
      tick();
      tick();
      check("reset_ld_ready", LW'(if1.ld_ready), LW'(0));
      check("reset_ld_done", LW'(if1.ld_done), LW'(0));
      check("reset_rd_valid", LW'(if1.rd_valid), LW'(0));
      check("reset_rd_data1", if1.rd_data, LW'(0));
      check("reset_rd_data0", if0.rd_data, LW'(0));
      RST = 1'b0;
      tick();
      check("reset_rd_ready", LW'(if1.rd_ready), LW'(1));

      // Known contents everywhere so every read is predictable.
      fill(DEPTH, 0, 1'b1);
      do_load("prefill", 0, DEPTH, 0, 0, 0, 0, -1);

      fill(16, 100, 1'b0);
      do_load("basic", 0, 16, 0, 0, 0, 0, -1);
      do_read("basic_rd", 4);

      fill(8, 32'hA0, 1'b0);
      do_load("top", 124, 8, 0, 0, 0, 0, -1);
      do_read("top_rd", 124);
      do_read("top_rd2", 127);

      fill(4, 32'h4000, 1'b0);
      do_load("bp", 60, 4, 1, 1, 0, 58, -1);

      fill(8, 1, 1'b0);
      do_load("old", 0, 8, 0, 0, 0, 0, -1);
      fill(2, 7, 1'b0);
      do_load("simul", 0, 2, 0, 0, 1, 0, -1);
      do_read("simul_rd", 0);

      do_load("zerolen", 0, 0, 0, 0, 0, 0, -1);
      do_read("zerolen_rd", 0);

      fill(10, 32'h5500, 1'b0);
      do_load("rstmid", 40, 10, 0, 0, 0, 40, 3);
      do_read("rstmid_rd", 40);

      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            int b, l;
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 12);
            fill(l, 0, 1'b1);
            do_load("rnd", b, l, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, DEPTH - 1), -1);
         end else begin
            int n, a;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
               a = $urandom_range(0, DEPTH - 1);
               rd_req  = 1'b1;
               rd_addr = ADDR_BIT'(a);
               tick();
               check_read("b2b", a);
               $display("read  b2b addr=%0d wrap=%h", a, if1.rd_data);
            end
            rd_req = 1'b0;
            tick();
            check("b2b_end", LW'(if1.rd_valid), LW'(0));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/bias_buffer_mlane.md
Name: bias_buffer_mlane

Overview:
- Parametrised next-generation bias SRAM for the int8 datapath. It holds per-output-channel 32-bit biases and returns LANES consecutive words per read, one word per PE column.
- Adds three things: a streaming burst loader with valid/ready, a read request/valid handshake on the rising edge, and a selectable wrap or zero-fill policy at the top of memory.
- Sits between the DMA/bias-load path and the post-accumulation bias adder.

Parameters:
- DATA_W, 32, bias word width in bits.
- ADDR_BIT, 7, address width; DEPTH = 2**ADDR_BIT words.
- LANES, 8, words returned per read (1..DEPTH).
- WRAP, 1, 1 = lane addresses wrap modulo DEPTH; 0 = lanes past DEPTH-1 read as 0.

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- ld_start  in  1  begin burst load; sampled only in IDLE.
- ld_base  in  ADDR_BIT  first write address of the burst.
- ld_len  in  ADDR_BIT+1  number of words in the burst (0..DEPTH).
- ld_valid  in  1  load data beat valid.
- ld_data  in  DATA_W  load data beat.
- ld_ready  out  1  high while in LOAD.
- ld_done  out  1  one-cycle pulse when a burst completes.
- rd_req  in  1  read request.
- rd_addr  in  ADDR_BIT  base address of the read.
- rd_ready  out  1  read accepted this cycle; high only in IDLE.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- rd_data  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset values: state=IDLE; ld_ready=0; ld_done=0; rd_valid=0; rd_data=0; load address/count cleared. RAM contents are not reset.
- FSM has two states, IDLE and LOAD.
  - IDLE -> LOAD on ld_start when ld_len != 0. Latch wr_ptr=ld_base and remaining=ld_len.
  - ld_start with ld_len=0: stay in IDLE, pulse ld_done the next cycle, perform no writes.
  - LOAD: a beat transfers when ld_valid && ld_ready. ram[wr_ptr] <= ld_data, wr_ptr increments modulo DEPTH (always wraps, independent of WRAP), remaining decrements.
  - On the beat where remaining==1: go to IDLE. ld_done pulses the following cycle, coinciding with ld_ready=0.
  - ld_valid low in LOAD: no write, no progress. There is no timeout.
  - ld_start while in LOAD is ignored.
- Read handshake:
  - rd_ready = (state==IDLE). A read is accepted when rd_req && rd_ready.
  - Latency is 1 cycle: rd_valid=1 and rd_data updated on the next posedge.
  - Back-to-back reads every cycle are legal. rd_data holds its last value when no read is accepted.
  - rd_req while in LOAD is not accepted; the requester holds rd_req until rd_ready.
- Lane addressing, for lane i with a = rd_addr + i computed in ADDR_BIT+1 bits:
  - WRAP=1: data = ram[a mod DEPTH].
  - WRAP=0: data = (a < DEPTH) ? ram[a] : 0.
- Simultaneous ld_start and rd_req in IDLE: both accepted. The read returns pre-load contents, because the first write cannot occur before the next cycle.
- Read and write hazard: impossible by construction, since reads are blocked in LOAD.
- Reset mid-load: return to IDLE next cycle with ld_done=0. Words already written are retained; the partial burst is abandoned.
- Reset on the cycle after an accepted read: rd_valid=0 and rd_data=0. Reset dominates.

Test Plan:
1. Load then read: ld_start base=0 len=16 with data 100+k, ld_valid held high. Expect ld_ready for 16 cycles, ld_done pulse on cycle 17. Then rd_addr=4 -> next cycle rd_valid=1, lanes 0..7 = 104..111.
2. Wrap mode (WRAP=1, DEPTH=128): load base=124 len=8 with data 0xA0..0xA7. Expect writes at 124..127 and 0..3. rd_addr=124 -> lanes = 0xA0..0xA7.
3. Zero-fill mode (WRAP=0): same load as scenario 2, rd_addr=124 -> lanes 0..3 = 0xA0..0xA3, lanes 4..7 = 0.
4. Backpressure and blocking: len=4 with ld_valid toggling 1,0,1,0,... Expect exactly 4 writes and ld_done after the 4th beat. Hold rd_req during the load -> rd_ready=0 throughout, accepted the first cycle after return to IDLE, rd_valid one cycle later.
5. Simultaneous and zero-length: ld_start(len=2, base=0, data 7,8) and rd_req(addr=0) in the same cycle over old contents 1..8. Expect the read to return old values 1..8 and the later read to show 7,8,3,...
   - Separately, ld_start with len=0 -> ld_done pulse next cycle, no writes, stays in IDLE.
6. Reset mid-load: len=10, assert RST after 3 beats. Expect next cycle state=IDLE, ld_ready=0, ld_done=0, rd_data=0. A subsequent read shows the 3 written words intact.
